// File: rtl/video_pkg.sv
// Shared video types for the sprite layer.
//   H_ACTIVE / V_ACTIVE : visible raster size
//   coord_t             : 10-bit pixel coordinate
//   rgb444_t            : 12-bit colour, 4 bits per channel
package video_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
endpackage

// File: rtl/sprite_layer_renderer_if.sv
// Bundle of raster, sprite control, ROM, palette and pixel-out signals.
//   master : video source / ROM / palette side (drives raster, rom_q, pal_*)
//   slave  : the renderer (drives rom_address, pal_index, red/green/blue, hit)
interface sprite_layer_renderer_if #(
  parameter int ADDR_W = 14,
  parameter int IDX_W  = 3
);
  import video_pkg::*;

  coord_t              DrawX;
  coord_t              DrawY;
  logic                blank;
  coord_t              sprite_x;
  coord_t              sprite_y;
  logic                sprite_en;
  logic                anim_en;
  logic [3:0]          bg_red;
  logic [3:0]          bg_green;
  logic [3:0]          bg_blue;
  logic [ADDR_W-1:0]   rom_address;
  logic [IDX_W-1:0]    rom_q;
  logic [IDX_W-1:0]    pal_index;
  logic [3:0]          pal_red;
  logic [3:0]          pal_green;
  logic [3:0]          pal_blue;
  logic [3:0]          red;
  logic [3:0]          green;
  logic [3:0]          blue;
  logic                hit;

  modport master (
    output DrawX, DrawY, blank, sprite_x, sprite_y, sprite_en, anim_en,
           bg_red, bg_green, bg_blue, rom_q, pal_red, pal_green, pal_blue,
    input  rom_address, pal_index, red, green, blue, hit
  );

  modport slave (
    input  DrawX, DrawY, blank, sprite_x, sprite_y, sprite_en, anim_en,
           bg_red, bg_green, bg_blue, rom_q, pal_red, pal_green, pal_blue,
    output rom_address, pal_index, red, green, blue, hit
  );
endinterface

// File: rtl/sprite_layer_renderer_addr_gen.sv
// sprite_addr_gen: shadow sprite position, animation frame counter, bounds
// test and ROM address generation, plus the first pipeline stage (S1).
//   i_draw_x/y, i_blank, i_bg : raster position, active flag, background
//   i_sprite_x/y, i_sprite_en, i_anim_en : sprite controls
//   o_rom_address : registered ROM address (held while out of bounds)
//   o_in_bounds, o_blank, o_sprite_en, o_bg : S1 copies for the delay line
module sprite_addr_gen
  import video_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int FRAMES      = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int FRAME_DIV   = 8,
  parameter int ADDR_W      = $clog2(FRAMES*IMG_W*IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  coord_t            i_draw_x,
  input  coord_t            i_draw_y,
  input  logic              i_blank,
  input  rgb444_t           i_bg,
  input  coord_t            i_sprite_x,
  input  coord_t            i_sprite_y,
  input  logic              i_sprite_en,
  input  logic              i_anim_en,
  output logic [ADDR_W-1:0] o_rom_address,
  output logic              o_in_bounds,
  output logic              o_blank,
  output logic              o_sprite_en,
  output rgb444_t           o_bg
);
  localparam int SPR_W    = IMG_W << SCALE_SHIFT;
  localparam int SPR_H    = IMG_H << SCALE_SHIFT;
  localparam int FRAME_SZ = IMG_W * IMG_H;
  localparam int FI_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  coord_t            r_px, r_py;
  logic [FI_W-1:0]   r_frame_idx;
  logic [DIV_W-1:0]  r_div_cnt;

  logic              w_frame_start;
  logic [10:0]       w_x_end, w_y_end, w_dx, w_dy, w_lx, w_ly;
  logic              w_in_bounds;
  logic [ADDR_W-1:0] w_addr;

  assign w_frame_start = (i_draw_x == '0) && (i_draw_y == '0);

  // 11-bit compare so a sprite hanging past the raster edge never wraps.
  assign w_x_end     = {1'b0, r_px} + 11'(SPR_W);
  assign w_y_end     = {1'b0, r_py} + 11'(SPR_H);
  assign w_in_bounds = ({1'b0, i_draw_x} >= {1'b0, r_px}) && ({1'b0, i_draw_x} < w_x_end) &&
                       ({1'b0, i_draw_y} >= {1'b0, r_py}) && ({1'b0, i_draw_y} < w_y_end);

  assign w_dx = {1'b0, i_draw_x} - {1'b0, r_px};
  assign w_dy = {1'b0, i_draw_y} - {1'b0, r_py};
  assign w_lx = w_dx >> SCALE_SHIFT;
  assign w_ly = w_dy >> SCALE_SHIFT;

  assign w_addr = ADDR_W'(r_frame_idx) * ADDR_W'(FRAME_SZ) +
                  ADDR_W'(w_ly) * ADDR_W'(IMG_W) + ADDR_W'(w_lx);

  // Position and animation only move at the top-left pixel so a frame is
  // always drawn from one consistent snapshot.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_px        <= '0;
      r_py        <= '0;
      r_frame_idx <= '0;
      r_div_cnt   <= '0;
    end else if (w_frame_start) begin
      r_px <= i_sprite_x;
      r_py <= i_sprite_y;
      if (i_anim_en) begin
        if (r_div_cnt == DIV_W'(FRAME_DIV - 1)) begin
          r_div_cnt   <= '0;
          r_frame_idx <= (r_frame_idx == FI_W'(FRAMES - 1)) ? '0 : r_frame_idx + FI_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rom_address <= '0;
      o_in_bounds   <= 1'b0;
      o_blank       <= 1'b0;
      o_sprite_en   <= 1'b0;
      o_bg          <= '0;
    end else begin
      if (w_in_bounds) o_rom_address <= w_addr;
      o_in_bounds <= w_in_bounds;
      o_blank     <= i_blank;
      o_sprite_en <= i_sprite_en;
      o_bg        <= i_bg;
    end
  end
endmodule

// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer: overlays one scaled, animated sprite on the
// background stream with a fixed 2+ROM_LAT cycle latency.
//   vga_clk, reset_n : pixel clock, async active-low reset
//   bus (slave)      : raster/sprite inputs, ROM + palette ports, pixel out
module sprite_layer_renderer
  import video_pkg::*;
#(
  parameter int IMG_W           = 64,
  parameter int IMG_H           = 64,
  parameter int FRAMES          = 4,
  parameter int IDX_W           = 3,
  parameter int SCALE_SHIFT     = 1,
  parameter int ROM_LAT         = 1,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FRAME_DIV       = 8,
  parameter int ADDR_W          = $clog2(FRAMES*IMG_W*IMG_H)
) (
  input logic                      vga_clk,
  input logic                      reset_n,
  sprite_layer_renderer_if.slave   bus
);
  rgb444_t w_bg, w_s1_bg, w_pal;
  logic    w_s1_inb, w_s1_blank, w_s1_sen, w_opaque;

  // ROM_LAT-deep alignment of the S1 side-band with rom_q.
  logic [ROM_LAT-1:0] r_blank_dl, r_inb_dl, r_sen_dl;
  rgb444_t            r_bg_dl [ROM_LAT];
  rgb444_t            r_rgb;
  logic               r_hit;

  assign w_bg  = {bus.bg_red, bus.bg_green, bus.bg_blue};
  assign w_pal = {bus.pal_red, bus.pal_green, bus.pal_blue};

  sprite_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FRAMES(FRAMES), .SCALE_SHIFT(SCALE_SHIFT),
    .FRAME_DIV(FRAME_DIV), .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .i_draw_x      (bus.DrawX),
    .i_draw_y      (bus.DrawY),
    .i_blank       (bus.blank),
    .i_bg          (w_bg),
    .i_sprite_x    (bus.sprite_x),
    .i_sprite_y    (bus.sprite_y),
    .i_sprite_en   (bus.sprite_en),
    .i_anim_en     (bus.anim_en),
    .o_rom_address (bus.rom_address),
    .o_in_bounds   (w_s1_inb),
    .o_blank       (w_s1_blank),
    .o_sprite_en   (w_s1_sen),
    .o_bg          (w_s1_bg)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_dl <= '0;
      r_inb_dl   <= '0;
      r_sen_dl   <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_bg_dl[i] <= '0;
    end else begin
      r_blank_dl[0] <= w_s1_blank;
      r_inb_dl[0]   <= w_s1_inb;
      r_sen_dl[0]   <= w_s1_sen;
      r_bg_dl[0]    <= w_s1_bg;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_blank_dl[i] <= r_blank_dl[i-1];
        r_inb_dl[i]   <= r_inb_dl[i-1];
        r_sen_dl[i]   <= r_sen_dl[i-1];
        r_bg_dl[i]    <= r_bg_dl[i-1];
      end
    end
  end

  assign bus.pal_index = bus.rom_q;
  assign w_opaque = r_sen_dl[ROM_LAT-1] && r_inb_dl[ROM_LAT-1] &&
                    (bus.rom_q != IDX_W'(TRANSPARENT_IDX));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= '0;
      r_hit <= 1'b0;
    end else if (!r_blank_dl[ROM_LAT-1]) begin
      r_rgb <= '0;
      r_hit <= 1'b0;
    end else if (w_opaque) begin
      r_rgb <= w_pal;
      r_hit <= 1'b1;
    end else begin
      r_rgb <= r_bg_dl[ROM_LAT-1];
      r_hit <= 1'b0;
    end
  end

  assign bus.red   = r_rgb.r;
  assign bus.green = r_rgb.g;
  assign bus.blue  = r_rgb.b;
  assign bus.hit   = r_hit;
endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer with an abstract pixel model.
module tb_sprite_layer_renderer;
  localparam int W = 64, H = 64, SC = 2, NFR = 4, FDIV = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sprite_layer_renderer_if #(.ADDR_W(14), .IDX_W(3)) bus ();

  sprite_layer_renderer #(.FRAME_DIV(FDIV)) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM image: index is the low three address bits; palette maps idx -> {idx^4,2,3}.
  function automatic logic [2:0] rom_fn(input logic [13:0] a);
    return a[2:0];
  endfunction
  function automatic logic [11:0] pal_fn(input logic [2:0] idx);
    return {4'({1'b0, idx}) ^ 4'h4, 4'h2, 4'h3};
  endfunction

  initial bus.rom_q = '0;
  always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_address);
  assign {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_fn(bus.pal_index);

  // Behavioural model state
  int m_px = 0, m_py = 0, m_fi = 0, m_div = 0, m_last_addr = 0;
  int g_sx = 0, g_sy = 0;
  bit g_anim = 1'b0;
  int exp_addr[int];
  int exp_out[int];
  int lit_addr[int];
  int lit_out[int];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_fi = 0; m_div = 0; m_last_addr = 0;
    exp_addr.delete(); exp_out.delete(); lit_addr.delete(); lit_out.delete();
  endtask

  // One pixel presented for exactly one clock. la/lo are optional literal
  // expectations (-1 = none) for rom_address and {hit,rgb}.
  task automatic apply(input int x, input int y, input bit blk, input bit sen,
                       input int bg, input int la, input int lo);
    bit inb;
    int a, o, idx;
    @(posedge clk); #1;
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.blank = blk; bus.sprite_en = sen;
    bus.sprite_x = 10'(g_sx); bus.sprite_y = 10'(g_sy); bus.anim_en = g_anim;
    {bus.bg_red, bus.bg_green, bus.bg_blue} = 12'(bg);
    inb = (x >= m_px) && (x < m_px + W*SC) && (y >= m_py) && (y < m_py + H*SC);
    if (inb) m_last_addr = m_fi*W*H + ((y - m_py)/SC)*W + (x - m_px)/SC;
    a = m_last_addr;
    idx = a % 8;
    if (!blk) o = 0;
    else if (sen && inb && idx != 0) o = 'h1000 | int'(pal_fn(3'(idx)));
    else o = bg & 'hFFF;
    exp_addr[cyc+1] = a;
    exp_out[cyc+3]  = o;
    if (la >= 0) lit_addr[cyc+1] = la;
    if (lo >= 0) lit_out[cyc+3]  = lo;
    if (x == 0 && y == 0) begin
      m_px = g_sx; m_py = g_sy;
      if (g_anim) begin
        m_div++;
        if (m_div == FDIV) begin m_div = 0; m_fi = (m_fi + 1) % NFR; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_addr.exists(cyc)) begin chk("addr_model", int'(bus.rom_address), exp_addr[cyc]); exp_addr.delete(cyc); end
      if (exp_out.exists(cyc)) begin chk("pix_model", int'({bus.hit, bus.red, bus.green, bus.blue}), exp_out[cyc]); exp_out.delete(cyc); end
      if (lit_addr.exists(cyc)) begin chk("addr_literal", int'(bus.rom_address), lit_addr[cyc]); lit_addr.delete(cyc); end
      if (lit_out.exists(cyc)) begin chk("pix_literal", int'({bus.hit, bus.red, bus.green, bus.blue}), lit_out[cyc]); lit_out.delete(cyc); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout n_bad=%0d", n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.DrawX = 10'd700; bus.DrawY = 10'd479; bus.blank = 1'b0; bus.sprite_en = 1'b1;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.anim_en = 1'b0;
    {bus.bg_red, bus.bg_green, bus.bg_blue} = 12'h000;
    #2;
    chk("reset_outputs", int'({bus.rom_address, bus.hit, bus.red, bus.green, bus.blue}), 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    // Position / scale / transparency / blank / enable
    g_sx = 100; g_sy = 50;
    apply(0, 0, 1, 1, 'hABC, -1, -1);
    apply(100, 50, 1, 1, 'hABC, 0, 'h0ABC);
    apply(101, 50, 1, 1, 'hABC, 0, -1);
    apply(102, 50, 1, 1, 'hABC, 1, -1);
    apply(105, 50, 1, 1, 'h5A5, -1, -1);
    apply(110, 50, 1, 1, 'hABC, 5, 'h1123);
    apply(227, 50, 1, 1, 'hABC, 63, -1);
    apply(228, 50, 1, 1, 'hABC, -1, 'h0ABC);
    apply(100, 52, 1, 1, 'hABC, 64, -1);
    apply(110, 50, 0, 1, 'hABC, -1, 'h0000);
    apply(110, 50, 1, 0, 'hABC, -1, 'h0ABC);

    // Mid-frame move
    g_sy = 150;
    apply(0, 0, 1, 1, 'hABC, -1, -1);
    apply(110, 200, 1, 1, 'hABC, 1605, 'h1123);
    g_sx = 300;
    apply(110, 201, 1, 1, 'hABC, 1605, 'h1123);
    apply(310, 250, 1, 1, 'hABC, -1, 'h0ABC);
    apply(0, 0, 1, 1, 'hABC, -1, -1);
    apply(310, 200, 1, 1, 'hABC, 1605, 'h1123);
    apply(110, 200, 1, 1, 'hABC, -1, 'h0ABC);

    // Animation held, then running
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 1, 1, 'hABC, -1, -1);
      apply(300, 150, 1, 1, 'hABC, 0, -1);
    end
    g_anim = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      apply(0, 0, 1, 1, 'hABC, -1, -1);
      apply(300, 150, 1, 1, 'hABC, (k == 2) ? 4096 : (k == 8) ? 0 : -1, -1);
    end

    // Asynchronous reset while the sprite is being drawn
    for (int k = 0; k < 4; k++) apply(310, 200, 1, 1, 'hABC, -1, 'h1123);
    @(negedge clk); #1;
    chk("hit_before_reset", int'(bus.hit), 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", int'({bus.rom_address, bus.hit, bus.red, bus.green, bus.blue}), 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    apply(310, 200, 1, 1, 'hABC, -1, 'h0ABC);
    apply(310, 250, 1, 1, 'hABC, -1, 'h0ABC);
    apply(0, 0, 1, 1, 'hABC, -1, -1);
    apply(310, 200, 1, 1, 'hABC, 1605, 'h1123);
    apply(700, 479, 0, 1, 'h000, -1, -1);
    repeat (5) @(posedge clk);
    #1;
    if (exp_out.size() != 0 || lit_out.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pending_expectations left=%0d expected=0", exp_out.size() + lit_out.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Parametrised successor to the single-image VGA ROM renderer; draws one positioned, integer-scaled, animated sprite over a background pixel stream.
- Sits between the VGA controller (DrawX/DrawY/blank) and the final colour mux.
- Drives an external sprite ROM and palette through ports, applies a transparent index and keeps the background pixel aligned through a fixed pipeline.

Parameters:
- IMG_W, 64, sprite width in source pixels.
- IMG_H, 64, sprite height in source pixels.
- FRAMES, 4, animation frames stored back-to-back in ROM.
- IDX_W, 3, palette index width.
- SCALE_SHIFT, 1, on-screen scale is 2^SCALE_SHIFT per axis.
- ROM_LAT, 1, ROM read latency in cycles, minimum 1.
- TRANSPARENT_IDX, 0, index treated as see-through.
- FRAME_DIV, 8, video frames per animation step, minimum 1.
- ADDR_W, $clog2(FRAMES*IMG_W*IMG_H), ROM address width (derived).

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- sprite_x  in  10  requested left edge; latched at frame start.
- sprite_y  in  10  requested top edge; latched at frame start.
- sprite_en  in  1  1 = draw sprite.
- anim_en  in  1  1 = advance animation.
- bg_red/bg_green/bg_blue  in  4 each  background pixel for the current DrawX/DrawY.
- rom_address  out  ADDR_W  ROM address (registered).
- rom_q  in  IDX_W  ROM data, ROM_LAT cycles after rom_address.
- pal_index  out  IDX_W  palette index (equals rom_q).
- pal_red/pal_green/pal_blue  in  4 each  combinational palette result.
- red/green/blue  out  4 each  final pixel.
- hit  out  1  opaque sprite pixel drawn.

Behaviour:
- Reset (async, reset_n=0) clears: red/green/blue/hit=0, rom_address=0, shadow position=0, frame_idx=0, div_cnt=0, all pipeline valid/blank/bounds bits=0. Reset mid-frame takes effect immediately; the first frame start after release latches the position.
- frame_start = (DrawX==0 && DrawY==0), sampled at input.
  - On frame_start: px<=sprite_x, py<=sprite_y.
  - If anim_en: div_cnt increments; at FRAME_DIV-1 it wraps to 0 and frame_idx<=(frame_idx+1) mod FRAMES.
  - If !anim_en: div_cnt and frame_idx hold.
  - Position changes mid-frame have no effect until the next frame start.
- Bounds use 11-bit unsigned math.
  - in_x = DrawX>=px && DrawX < px+(IMG_W<<SCALE_SHIFT).
  - in_y is the same using DrawY, py and IMG_H.
  - A sprite running past 639/479 is clipped naturally. Negative positions are unsupported.
- Source coordinates: lx=(DrawX-px)>>SCALE_SHIFT and ly=(DrawY-py)>>SCALE_SHIFT.
- Address: frame_idx*IMG_W*IMG_H + ly*IMG_W + lx. When out of bounds, rom_address holds its previous value.
- Pipeline:
  - S1 (cycle+1): rom_address, in_bounds, blank and bg registered.
  - Delay line: blank, in_bounds and bg pass through ROM_LAT more stages.
  - Output register at cycle+2+ROM_LAT. Default latency is 3 cycles, fixed, regardless of bounds.
- Output select (registered):
  - blank_d=0: rgb=0, hit=0.
  - else if sprite_en_d && in_bounds_d && rom_q!=TRANSPARENT_IDX: rgb=pal_*, hit=1.
  - else: rgb=bg_*_d, hit=0.
- sprite_en is delayed with the pipeline so toggling it is pixel-accurate.

Decomposition:
- Package video_pkg: H_ACTIVE=640, V_ACTIVE=480, coord_t (logic[9:0]), rgb444_t struct {r,g,b}.
- Sub-module sprite_addr_gen: shadow position, animation counter, bounds test, address and S1 registers.
- Top level: delay lines and output mux.

Test Plan:
- Reset: pull reset_n low at DrawY=200 while hit=1 -> red/green/blue/hit=0 and rom_address=0 without waiting for a clock edge; after release, sprite appears only in the following frame.
- Position/scale (sprite_x=100, sprite_y=50, defaults), checking rom_address one cycle after input:
  - DrawY=50: DrawX=100 and 101 -> 0; DrawX=102 -> 1; DrawX=227 -> 63; DrawX=228 -> output equals bg with hit=0.
  - DrawY=52, DrawX=100 -> address 64.
- Transparency, with bg=12'hABC and pal=12'h123:
  - rom_q=0 -> output 12'hABC, 3 cycles after input.
  - rom_q=5 -> output 12'h123, hit=1.
- Blank: blank=0 with rom_q=5 in bounds -> rgb=0 and hit=0, 3 cycles later.
- Animation (FRAME_DIV=2, FRAMES=4):
  - After 2 frame starts, the address at the sprite origin is 4096.
  - After 8 frame starts it wraps to 0.
  - With anim_en=0 the address stays constant.
- Mid-frame move: change sprite_x 100->300 at DrawY=200 -> rows 200-479 unchanged; new position applies from the next (0,0).
